wb_spi_mailbox: RTL and testbench

WB_SPI_MAILBOX -- requirements
Module: wb_spi_mailbox

---
 rtl/wb_spi_mbx_pkg.sv | 15 +
 rtl/mbx_slot.sv | 72 +++++++
 rtl/wb_spi_mailbox.sv | 113 +++++++++++
 tb/tb_wb_spi_mailbox.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_spi_mbx_pkg.sv
// Shared types and default sizing for the Wishbone-to-SPI command mailbox.
package wb_spi_mbx_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        ISSU = 2'd2,
        DONE = 2'd3
    } slot_state_t;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 8;
    localparam int DEPTH_DEF = 16;

endpackage

// File: rtl/mbx_slot.sv
// One mailbox slot: lifecycle state plus the command payload and its completion data.
module mbx_slot
    import wb_spi_mbx_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          post,
    input  logic          post_we,
    input  logic [AW-1:0] post_addr,
    input  logic [DW-1:0] post_wdata,
    input  logic          issue,
    input  logic          done,
    input  logic [DW-1:0] done_rdata,
    input  logic          done_err,
    input  logic          retire,
    output slot_state_t   state,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          err
);

    slot_state_t state_q, state_d;
    logic        take, land;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FREE;
        else     state_q <= state_d;
    end

    // Each strobe only acts when the slot is in the matching state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FREE: if (post)   state_d = PEND;
            PEND: if (issue)  state_d = ISSU;
            ISSU: if (done)   state_d = DONE;
            DONE: if (retire) state_d = FREE;
        endcase
    end

    always_comb begin
        take  = (state_q == FREE) && post;
        land  = (state_q == ISSU) && done;
        state = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            if (take) begin
                we    <= post_we;
                addr  <= post_addr;
                wdata <= post_wdata;
            end
            if (land) begin
                rdata <= done_rdata;
                err   <= done_err;
            end
        end
    end

endmodule

// File: rtl/wb_spi_mailbox.sv
// Tagged command mailbox: Wishbone posts commands in order, SPI completes them out of
// order, responses return to Wishbone in post order.
module wb_spi_mailbox
    import wb_spi_mbx_pkg::*;
#(
    parameter  int DW    = DW_DEF,
    parameter  int AW    = AW_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic [TW-1:0] req_tag,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [TW-1:0] rsp_tag,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic          cmd_we,
    output logic [AW-1:0] cmd_addr,
    output logic [DW-1:0] cmd_wdata,
    output logic [TW-1:0] cmd_tag,
    input  logic          done_valid,
    input  logic [TW-1:0] done_tag,
    input  logic [DW-1:0] done_rdata,
    input  logic          done_err,
    output logic [TW:0]   level,
    output logic          proto_err
);

    localparam int LW = TW + 1;

    logic [TW-1:0] alloc, issue, retire;

    slot_state_t [DEPTH-1:0]         st;
    logic        [DEPTH-1:0]         we_v, err_v;
    logic        [DEPTH-1:0][AW-1:0] addr_v;
    logic        [DEPTH-1:0][DW-1:0] wdata_v, rdata_v;

    logic post_fire, issue_fire, retire_fire, done_bad;

    // req_ready depends on the registered level only, so a retire at full frees a
    // post slot no earlier than the following cycle.
    assign req_ready   = (level != LW'(DEPTH));
    assign req_tag     = alloc;
    assign post_fire   = req_valid && req_ready;
    assign issue_fire  = cmd_valid && cmd_ready;
    assign retire_fire = rsp_valid && rsp_ready;
    assign done_bad    = done_valid && (st[done_tag] != ISSU);

    // Command and response views are decoded straight from slot registers, so they
    // stay stable until the handshake moves the slot on.
    assign cmd_valid = (st[issue] == PEND);
    assign cmd_tag   = issue;
    assign cmd_we    = we_v[issue];
    assign cmd_addr  = addr_v[issue];
    assign cmd_wdata = wdata_v[issue];

    assign rsp_valid = (st[retire] == DONE);
    assign rsp_tag   = retire;
    assign rsp_rdata = rdata_v[retire];
    assign rsp_err   = err_v[retire];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        mbx_slot #(.DW(DW), .AW(AW)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .post       (post_fire && (alloc == TW'(i))),
            .post_we    (req_we),
            .post_addr  (req_addr),
            .post_wdata (req_wdata),
            .issue      (issue_fire && (issue == TW'(i))),
            .done       (done_valid && (done_tag == TW'(i))),
            .done_rdata (done_rdata),
            .done_err   (done_err),
            .retire     (retire_fire && (retire == TW'(i))),
            .state      (st[i]),
            .we         (we_v[i]),
            .addr       (addr_v[i]),
            .wdata      (wdata_v[i]),
            .rdata      (rdata_v[i]),
            .err        (err_v[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc     <= '0;
            issue     <= '0;
            retire    <= '0;
            level     <= '0;
            proto_err <= 1'b0;
        end else begin
            if (post_fire)   alloc  <= alloc + TW'(1);
            if (issue_fire)  issue  <= issue + TW'(1);
            if (retire_fire) retire <= retire + TW'(1);
            unique case ({post_fire, retire_fire})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (done_bad) proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_spi_mailbox.sv
// Randomized and directed bench for wb_spi_mailbox against a queue-based mailbox model.
module tb_wb_spi_mailbox;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic [TW-1:0] req_tag;
    logic          rsp_valid, rsp_err;
    logic          rsp_ready = 1'b0;
    logic [TW-1:0] rsp_tag;
    logic [DW-1:0] rsp_rdata;
    logic          cmd_valid, cmd_we;
    logic          cmd_ready = 1'b0;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [TW-1:0] cmd_tag;
    logic          done_valid = 1'b0, done_err = 1'b0;
    logic [TW-1:0] done_tag = '0;
    logic [DW-1:0] done_rdata = '0;
    logic [TW:0]   level;
    logic          proto_err;

    wb_spi_mailbox #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_tag(cmd_tag),
        .done_valid(done_valid), .done_tag(done_tag), .done_rdata(done_rdata),
        .done_err(done_err), .level(level), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Model: commands waiting for issue, commands awaiting retirement (post order),
    // and per-tag payload / progress flags.
    int          pend_q[$];
    int          ret_q[$];
    bit          m_we[DEPTH];
    bit [AW-1:0] m_addr[DEPTH];
    bit [DW-1:0] m_wdata[DEPTH];
    bit [DW-1:0] m_rdata[DEPTH];
    bit          m_err[DEPTH];
    bit          m_iss[DEPTH];
    bit          m_dn[DEPTH];
    int          m_alloc;
    bit          m_proto;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        pend_q.delete();
        ret_q.delete();
        for (int t = 0; t < DEPTH; t++) begin
            m_iss[t] = 1'b0;
            m_dn[t]  = 1'b0;
        end
        m_alloc = 0;
        m_proto = 1'b0;
    endtask

    task automatic check_all();
        int h;
        bit exp_rsp;
        chk("req_ready", 64'(req_ready), 64'(ret_q.size() != DEPTH));
        chk("req_tag", 64'(req_tag), 64'(m_alloc));
        chk("level", 64'(level), 64'(ret_q.size()));
        chk("proto_err", 64'(proto_err), 64'(m_proto));
        chk("cmd_valid", 64'(cmd_valid), 64'(pend_q.size() != 0));
        if (pend_q.size() != 0 && cmd_valid) begin
            h = pend_q[0];
            chk("cmd_tag", 64'(cmd_tag), 64'(h));
            chk("cmd_we", 64'(cmd_we), 64'(m_we[h]));
            chk("cmd_addr", 64'(cmd_addr), 64'(m_addr[h]));
            chk("cmd_wdata", 64'(cmd_wdata), 64'(m_wdata[h]));
        end
        exp_rsp = (ret_q.size() != 0) && m_dn[ret_q[0]];
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
        if (exp_rsp && rsp_valid) begin
            h = ret_q[0];
            chk("rsp_tag", 64'(rsp_tag), 64'(h));
            chk("rsp_err", 64'(rsp_err), 64'(m_err[h]));
            if (!m_we[h]) chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata[h]));
        end
    endtask

    // One clock: decide handshakes from the model, advance it at the edge, then compare.
    task automatic step();
        bit p, is, rt, dn, bad;
        int h;
        p   = req_valid && (ret_q.size() != DEPTH);
        is  = cmd_ready && (pend_q.size() != 0);
        rt  = rsp_ready && (ret_q.size() != 0) && m_dn[ret_q[0]];
        dn  = done_valid && m_iss[done_tag] && !m_dn[done_tag];
        bad = done_valid && !dn;
        @(posedge clk);
        if (rt) begin
            h = ret_q.pop_front();
            m_iss[h] = 1'b0;
            m_dn[h]  = 1'b0;
        end
        if (dn) begin
            m_dn[done_tag]    = 1'b1;
            m_rdata[done_tag] = done_rdata;
            m_err[done_tag]   = done_err;
        end
        if (bad) m_proto = 1'b1;
        if (is) begin
            h = pend_q.pop_front();
            m_iss[h] = 1'b1;
        end
        if (p) begin
            h = m_alloc;
            m_we[h] = req_we; m_addr[h] = req_addr; m_wdata[h] = req_wdata;
            m_iss[h] = 1'b0; m_dn[h] = 1'b0;
            pend_q.push_back(h);
            ret_q.push_back(h);
            m_alloc = (m_alloc + 1) % DEPTH;
        end
        #1 check_all();
    endtask

    task automatic idle();
        req_valid = 1'b0; cmd_ready = 1'b0; rsp_ready = 1'b0; done_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        model_clear();
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_proto", 64'(proto_err), 64'(0));
        chk("rst_cmd_addr", 64'(cmd_addr), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check_all();
    endtask

    task automatic do_done(input int t, input logic [DW-1:0] d);
        done_valid = 1'b1; done_tag = TW'(t); done_rdata = d; done_err = 1'b0;
        step();
        done_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_rd [3];
        int inflight[$];
        exp_rd[0] = 32'hA; exp_rd[1] = 32'hB; exp_rd[2] = 32'hC;

        do_reset();
        chk("rst_req_ready", 64'(req_ready), 64'(1));

        // Single write round trip.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h12; req_wdata = 32'hDEADBEEF;
        cmd_ready = 1'b1;
        step();
        chk("r18_cmd_valid", 64'(cmd_valid), 64'(1));
        chk("r18_cmd_tag", 64'(cmd_tag), 64'(0));
        req_valid = 1'b0;
        step();
        cmd_ready = 1'b0;
        do_done(0, 32'h0);
        chk("r18_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("r18_rsp_tag", 64'(rsp_tag), 64'(0));
        chk("r18_rsp_err", 64'(rsp_err), 64'(0));
        rsp_ready = 1'b1;
        step();
        idle();

        // Fill to full, then retire one: no bypass.
        do_reset();
        req_valid = 1'b1; req_we = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            req_addr = 8'($urandom); req_wdata = $urandom;
            step();
        end
        chk("r19_level_full", 64'(level), 64'(16));
        chk("r19_ready_full", 64'(req_ready), 64'(0));
        req_valid = 1'b0; cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        do_done(0, 32'h55);
        rsp_ready = 1'b1; req_valid = 1'b1;
        #0 chk("r19_ready_same", 64'(req_ready), 64'(0));
        step();
        chk("r19_ready_after", 64'(req_ready), 64'(1));
        rsp_ready = 1'b0;
        step();
        idle();

        // Out-of-order completion, in-order response, with a held response.
        do_reset();
        req_valid = 1'b1; req_we = 1'b0; cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_addr = 8'(k); req_wdata = $urandom;
            step();
        end
        req_valid = 1'b0;
        repeat (2) step();
        cmd_ready = 1'b0;
        do_done(2, 32'hC);
        do_done(0, 32'hA);
        do_done(1, 32'hB);
        for (int k = 0; k < 4; k++) begin
            chk("r23_hold_tag", 64'(rsp_tag), 64'(0));
            chk("r23_hold_rdata", 64'(rsp_rdata), 64'(32'hA));
            step();
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #0 chk("r20_rsp_tag", 64'(rsp_tag), 64'(k));
            chk("r20_rsp_rdata", 64'(rsp_rdata), 64'(exp_rd[k]));
            step();
        end
        idle();

        // Completion for a free slot.
        done_valid = 1'b1; done_tag = 4'd5; done_rdata = 32'h1234; done_err = 1'b1;
        step();
        done_valid = 1'b0;
        chk("r21_proto", 64'(proto_err), 64'(1));
        chk("r21_level", 64'(level), 64'(0));
        repeat (3) step();
        chk("r21_proto_sticky", 64'(proto_err), 64'(1));

        // Reset with work outstanding.
        do_reset();
        req_valid = 1'b1; cmd_ready = 1'b1;
        repeat (4) begin
            req_addr = 8'($urandom); req_wdata = $urandom; req_we = 1'($urandom);
            step();
        end
        req_valid = 1'b0;
        step();
        cmd_ready = 1'b0;
        do_done(1, 32'h77);
        step();
        do_reset();
        chk("r22_level", 64'(level), 64'(0));
        chk("r22_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("r22_next_tag", 64'(req_tag), 64'(0));
        req_valid = 1'b1;
        step();
        chk("r22_cmd_tag", 64'(cmd_tag), 64'(0));
        idle();

        // Random traffic with out-of-order completions; wraps the rings many times.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            req_valid = ($urandom_range(0, 99) < 60);
            req_we    = 1'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = $urandom;
            cmd_ready = ($urandom_range(0, 99) < 55);
            rsp_ready = ($urandom_range(0, 99) < 50);
            inflight.delete();
            for (int t = 0; t < DEPTH; t++)
                if (m_iss[t] && !m_dn[t]) inflight.push_back(t);
            done_valid = 1'b0;
            if (inflight.size() != 0 && $urandom_range(0, 99) < 50) begin
                done_valid = 1'b1;
                done_tag   = TW'(inflight[$urandom_range(0, inflight.size() - 1)]);
                done_rdata = $urandom;
                done_err   = ($urandom_range(0, 9) == 0);
            end
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
